// File: rtl/life_grid_engine.sv
// Cellular automaton engine: ROWS x COLS grid advancing one generation per qualified tick,
// with selectable edge mode, birth/survival masks, run/idle/halt control and still-life detection.
module life_grid_engine #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int GEN_W = 16,
   parameter int WRAP  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 single,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] load_pattern,
   input  logic [8:0]           birth_mask,
   input  logic [8:0]           survive_mask,
   input  logic                 halt_on_still,
   output logic [ROWS*COLS-1:0] cells,
   output logic [GEN_W-1:0]     generation,
   output logic [1:0]           state,
   output logic                 stable,
   output logic                 extinct,
   output logic                 gen_overflow,
   output logic                 advanced
);

   localparam int N = ROWS * COLS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic           adv;
   logic [N-1:0]   next_cells;

   if (ROWS < 3 || COLS < 3) begin : g_bad_size
      $error("life_grid_engine: ROWS and COLS must both be at least 3");
   end

   // Neighbour taps are resolved at elaboration: out-of-grid taps become constant 0 unless wrapping.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [8:0] nb;
         logic [3:0] n;
         for (genvar k = 0; k < 9; k++) begin : g_nb
            localparam int DR = k / 3 - 1;
            localparam int DC = k % 3 - 1;
            localparam int RR = (WRAP != 0) ? (r + DR + ROWS) % ROWS : r + DR;
            localparam int CC = (WRAP != 0) ? (c + DC + COLS) % COLS : c + DC;
            if (k == 4 || RR < 0 || RR >= ROWS || CC < 0 || CC >= COLS) begin : g_dead
               assign nb[k] = 1'b0;
            end else begin : g_tap
               assign nb[k] = cells[RR*COLS+CC];
            end
         end
         assign n = {3'd0, nb[0]} + {3'd0, nb[1]} + {3'd0, nb[2]}
                  + {3'd0, nb[3]} + {3'd0, nb[4]} + {3'd0, nb[5]}
                  + {3'd0, nb[6]} + {3'd0, nb[7]} + {3'd0, nb[8]};
         assign next_cells[r*COLS+c] = cells[r*COLS+c] ? survive_mask[n] : birth_mask[n];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Priority load > stop > start > advance; start in RUN falls through so ena still advances.
   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      if (load || stop) begin
         state_d = IDLE;
      end else if (start && state_q != RUN) begin
         state_d = RUN;
      end else begin
         adv = (state_q == RUN && ena) || (state_q == IDLE && single);
         if (adv && state_q == RUN && halt_on_still &&
             (next_cells == cells || next_cells == '0))
            state_d = HALTED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cells        <= '0;
         generation   <= '0;
         stable       <= 1'b0;
         gen_overflow <= 1'b0;
         advanced     <= 1'b0;
      end else begin
         advanced <= adv;
         if (load) begin
            cells        <= load_pattern;
            generation   <= '0;
            stable       <= 1'b0;
            gen_overflow <= 1'b0;
         end else if (adv) begin
            cells      <= next_cells;
            generation <= generation + 1'b1;
            stable     <= (next_cells == cells);
            if (&generation) gen_overflow <= 1'b1;
         end
      end
   end

   assign state   = state_q;
   assign extinct = ~|cells;

endmodule

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Conway-style cellular automaton engine. It holds a ROWS×COLS grid of cell state and advances one generation per qualified enable. Edge handling, birth rule and survival rule are all selectable. A run/idle/halt state machine, a generation counter and still-life/extinction detection are included. It sits between the pattern source and the LED array driver, and the top level supplies the slow game tick on `ena`.

## Interface
- `ROWS`, default 8: grid height; must be ≥3 (elaboration error otherwise).
- `COLS`, default 8: grid width; must be ≥3.
- `GEN_W`, default 16: generation counter width.
- `WRAP`, default 0: edge mode. 0 treats cells outside the grid as dead; 1 wraps the grid as a torus.

Cell (r,c) lives at bit index r*COLS+c in every grid vector.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  generation tick; qualified by state.
- `start`  in  1  enter RUN.
- `stop`  in  1  enter IDLE.
- `single`  in  1  advance exactly one generation while in IDLE.
- `load`  in  1  load a new pattern.
- `load_pattern`  in  ROWS*COLS  pattern captured on `load`.
- `birth_mask`  in  9  bit k=1: a dead cell with k live neighbours is born. Conway rule: 9'h008.
- `survive_mask`  in  9  bit k=1: a live cell with k live neighbours survives. Conway rule: 9'h00C.
- `halt_on_still`  in  1  auto-halt when a still life or an empty grid is reached.
- `cells`  out  ROWS*COLS  current grid (registered).
- `generation`  out  GEN_W  generations since the last load or reset.
- `state`  out  2  0 = IDLE, 1 = RUN, 2 = HALTED.
- `stable`  out  1  the last advance produced no change.
- `extinct`  out  1  `~|cells` (combinational from the register).
- `gen_overflow`  out  1  sticky; set when `generation` wraps.
- `advanced`  out  1  one-cycle pulse after each advance.

## Operation
- Neighbour count n is 0..8 and 4 bits wide. It counts the 8 surrounding cells, using out-of-grid cells per `WRAP`.
- Next-state rule: next = cell ? survive_mask[n] : birth_mask[n]. All cells update simultaneously from the current grid.
- Masks are sampled on the advancing edge only. Changing them mid-run takes effect on the next advance.
- An advance occurs when either condition holds:
  - state=RUN and `ena`=1, or
  - state=IDLE and `single`=1.
- An advance does all of the following:
  - cells ← next;
  - generation ← generation+1, modulo 2^GEN_W; on a wrap to 0, gen_overflow ← 1;
  - stable ← (next == cells);
  - advanced ← 1.
- Per-cycle priority, highest first: `rst` > `load` > `stop` > `start` > advance.
- `load` (any state): cells ← load_pattern; generation, stable, gen_overflow ← 0; state ← IDLE. No advance occurs that cycle.
- FSM transitions:
  - IDLE → RUN on `start`.
  - RUN → IDLE on `stop`; `stop` with `ena` in the same cycle does not advance.
  - RUN → HALTED when an advance with `halt_on_still`=1 yields next==cells or next==0.
  - HALTED → RUN on `start`. HALTED → IDLE on `stop` or `load`.
- Ignored inputs:
  - `start` in RUN;
  - `single` outside IDLE;
  - `ena` outside RUN;
  - `start` and `stop` together, where `stop` wins.
- HALTED holds cells and generation constant regardless of `ena`.

## Timing
- Reset values: cells=0, generation=0, state=IDLE, stable=0, gen_overflow=0, advanced=0; extinct=1 as a consequence.
- Reset mid-run clears everything at the next edge; the in-flight advance is discarded.
- Advance latency is 1 cycle. Next-state logic is combinational from `cells`, and `cells`, `generation`, `stable` and `state` all update on the edge that samples the qualifying `ena` or `single`.
- `advanced` is high for exactly the cycle following that edge.
- Back-to-back advances are permitted every cycle (`ena` held high in RUN). Generation then increments by 1 per cycle.
- The HALTED transition occurs on the same edge as the advance that triggered it. That advance is counted in `generation`.
- `load_pattern` is sampled only on the `load` edge.

## Test plan
- **Blinker, dead edges** (5×5, WRAP=0, Conway masks): load bits {11,12,13}, start, then 1 `ena` → cells = bits {7,12,17}, generation=1, stable=0. A 2nd `ena` → bits {11,12,13}, generation=2.
- **Still life auto-halt**: 2×2 block at bits {9,10,17,18} (8×8), halt_on_still=1, start, then `ena` held → after the first advance stable=1, state=HALTED, generation=1. Further `ena` changes nothing.
- **Torus glider** (8×8, WRAP=1): load a glider, start, 32 `ena` pulses → cells equal the loaded pattern and generation=32. With WRAP=0, the same stimulus ends with cells ≠ the loaded pattern.
- **Counter wrap** (GEN_W=4): blinker, 16 advances → generation=0, gen_overflow=1. A subsequent `load` clears gen_overflow to 0.
- **Priority**:
  - In RUN, `load`+`ena` same cycle → cells=load_pattern, generation=0, state=IDLE, no `advanced` pulse.
  - `stop`+`ena` → state=IDLE, cells unchanged.
  - `single` in IDLE → exactly one advance.
- **Reset mid-run and HighLife rule**: `rst` during RUN → all outputs return to their reset values next cycle. Then birth_mask=9'h048 (B36), survive_mask=9'h00C: a dead cell with 6 live neighbours is alive after one `single` step.
